// File: rtl/wb_port_arbiter_if.sv
// Write-back port bundle: pipeline WB request, multi-cycle result handshake,
// and the register-file write port produced by the arbiter.
interface wb_port_arbiter_if;
    logic        p_wreg;
    logic [4:0]  p_rn;
    logic [31:0] p_d;
    logic        m_valid;
    logic [4:0]  m_rn;
    logic [31:0] m_d;
    logic        m_ready;
    logic        p_stall;
    logic        wwreg;
    logic [4:0]  wrn;
    logic [31:0] wdi;

    modport master (
        output p_wreg, p_rn, p_d, m_valid, m_rn, m_d,
        input  m_ready, p_stall, wwreg, wrn, wdi
    );

    modport slave (
        input  p_wreg, p_rn, p_d, m_valid, m_rn, m_d,
        output m_ready, p_stall, wwreg, wrn, wdi
    );
endinterface

// File: rtl/wb_port_arbiter.sv
// Shares the single register-file write port between the pipeline WB stage and
// a 2-entry buffer of multi-cycle results, with a starvation guard for the buffer.
module wb_port_arbiter #(
    parameter int STARVE_LIM = 3
) (
    input logic               clk,
    input logic               clrn,
    wb_port_arbiter_if.slave  bus
);
    typedef enum logic [1:0] {GNT_IDLE, GNT_PIPE, GNT_BUF} grant_e;

    localparam logic [1:0] LIM = 2'(STARVE_LIM);

    logic [4:0]  rn_q  [2];
    logic [31:0] dat_q [2];
    logic        wp_q, wp_d;
    logic        rp_q, rp_d;
    logic [1:0]  cnt_q, cnt_d;
    logic [1:0]  starve_q, starve_d;

    logic        empty, full, forced, push, pop;
    grant_e      grant;

    always_comb begin
        empty  = (cnt_q == 2'd0);
        full   = (cnt_q == 2'd2);
        forced = (starve_q == LIM) && !empty;
        if (bus.p_wreg && !forced)
            grant = GNT_PIPE;
        else if (!empty)
            grant = GNT_BUF;
        else
            grant = GNT_IDLE;
        push = bus.m_valid && !full;
        pop  = (grant == GNT_BUF);
    end

    // Pointers and occupancy; full blocks push, so push+pop at full cannot overflow.
    always_comb begin
        wp_d = wp_q ^ push;
        rp_d = rp_q ^ pop;
        unique case ({push, pop})
            2'b10:   cnt_d = cnt_q + 2'd1;
            2'b01:   cnt_d = cnt_q - 2'd1;
            default: cnt_d = cnt_q;
        endcase
        if (empty || grant == GNT_BUF)
            starve_d = 2'd0;
        else if (grant == GNT_PIPE && starve_q != LIM)
            starve_d = starve_q + 2'd1;
        else
            starve_d = starve_q;
    end

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            wp_q     <= 1'b0;
            rp_q     <= 1'b0;
            cnt_q    <= 2'd0;
            starve_q <= 2'd0;
        end else begin
            wp_q     <= wp_d;
            rp_q     <= rp_d;
            cnt_q    <= cnt_d;
            starve_q <= starve_d;
        end
    end

    // Entry storage needs no reset: occupancy alone decides what is valid.
    always_ff @(posedge clk) begin
        if (push) begin
            rn_q[wp_q]  <= bus.m_rn;
            dat_q[wp_q] <= bus.m_d;
        end
    end

    always_comb begin
        bus.m_ready = !full;
        bus.p_stall = forced && bus.p_wreg;
        unique case (grant)
            GNT_PIPE: begin
                bus.wrn = bus.p_rn;
                bus.wdi = bus.p_d;
            end
            GNT_BUF: begin
                bus.wrn = rn_q[rp_q];
                bus.wdi = dat_q[rp_q];
            end
            default: begin
                bus.wrn = 5'd0;
                bus.wdi = 32'd0;
            end
        endcase
        // r0 is hard-wired zero; a buffered r0 result is still consumed.
        bus.wwreg = (grant != GNT_IDLE) && (bus.wrn != 5'd0);
    end
endmodule
